// File: rtl/sp_unit_pkg.sv
// Shared types for the special-purpose execution unit: issue operands,
// op encodings, writeback result record and the bit-count helpers.
package sp_unit_pkg;

  localparam int ID_W = 3;
  typedef logic [ID_W-1:0] id_t;

  // fn3 carries a wide function field; only its low three bits select the op.
  typedef struct packed {
    logic [6:0]  fn3;
    logic [6:0]  fn7;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } sp_inputs_t;

  typedef enum logic [2:0] {
    SP_BSWAP  = 3'd0,
    SP_POPCNT = 3'd1,
    SP_CLZ    = 3'd2,
    SP_CRC    = 3'd3
  } sp_op_t;

  typedef struct packed {
    id_t         id;
    logic [31:0] rd;
  } sp_result_t;

  // Castagnoli polynomial, reflected form.
  localparam logic [31:0] SP_CRC32C_POLY = 32'h82F63B78;

  function automatic logic [5:0] sp_popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

  // Zero input yields 32.
  function automatic logic [5:0] sp_clz(input logic [31:0] v);
    logic [5:0] n;
    logic       found;
    n     = '0;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) begin
          found = 1'b1;
        end else begin
          n = n + 6'd1;
        end
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/sp_unit_fifo.sv
// In-order result buffer with distributed-RAM storage and combinational head.
// The head output holds the last consumed entry while the buffer is empty so
// downstream sees stable id/data outside of valid.
module sp_unit_fifo #(
  parameter int DATA_WIDTH = 35,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  full
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [DATA_WIDTH-1:0] last_reg;
  logic                  pop_eff;

  assign valid   = (count_reg != '0);
  assign full    = (count_reg == FULL_CNT);
  assign pop_eff = pop & valid;
  assign data_out = valid ? mem[rd_ptr_reg] : last_reg;

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  // Pointer, occupancy and last-consumed tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      last_reg   <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_eff) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        last_reg   <= mem[rd_ptr_reg];
      end
      case ({push, pop_eff})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/sp_unit.sv
// Special-purpose execution unit: byte-swap, popcount, clz (single cycle)
// and a four-cycle bytewise CRC32 step, with in-order buffered writeback.
// Optional: define SP_UNIT_CRC32C_EN to let fn3=3/fn7=1 use the Castagnoli
// polynomial; otherwise CRC_POLY is always used and fn7 is ignored.
module sp_unit import sp_unit_pkg::*; #(
  parameter int          RESULT_DEPTH = 2,
  parameter logic [31:0] CRC_POLY     = 32'hEDB88320
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_new_request,
  output logic       issue_ready,
  input  id_t        issue_id,
  input  sp_inputs_t sp_inputs,
  output logic       wb_done,
  input  logic       wb_ack,
  output id_t        wb_id,
  output logic [31:0] wb_rd
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CRC  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  // One reflected CRC byte step: eight shift/xor iterations.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc,
                                           input logic [7:0]  data,
                                           input logic [31:0] poly);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ poly) : (c >> 1);
    end
    return c;
  endfunction

  logic [1:0]  state_reg;
  logic [1:0]  byte_idx_reg;
  logic [31:0] crc_reg, rs1_reg;
  id_t         id_reg;
  logic [31:0] crc_poly;
  logic [31:0] crc_next;
  logic [7:0]  cur_byte;
  logic [2:0]  op;
  logic [31:0] bswap_res, single_res;
  logic        accept, space, push, fifo_full, fifo_valid;
  sp_result_t  fifo_din, fifo_dout;

`ifdef SP_UNIT_CRC32C_EN
  logic [31:0] poly_reg;
  logic        unused_fields;
  assign unused_fields = ^sp_inputs.fn3[6:3];
  assign crc_poly = poly_reg;

  // Polynomial is chosen once, when the CRC op is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poly_reg <= CRC_POLY;
    end else if (state_reg == IDLE && accept && op == SP_CRC) begin
      poly_reg <= (sp_inputs.fn7 == 7'h01) ? SP_CRC32C_POLY : CRC_POLY;
    end
  end
`else
  logic unused_fields;
  assign unused_fields = ^{sp_inputs.fn3[6:3], sp_inputs.fn7};
  assign crc_poly = CRC_POLY;
`endif

  assign op = sp_inputs.fn3[2:0];

  // A pop in the same cycle frees the slot being written.
  assign space       = ~fifo_full | wb_ack;
  assign issue_ready = ~rst & (state_reg == IDLE) & space;
  assign accept      = issue_new_request & issue_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bswap
      assign bswap_res[8*gi +: 8] = sp_inputs.rs1[8*(3-gi) +: 8];
    end
  endgenerate

  assign cur_byte = rs1_reg[{byte_idx_reg, 3'b000} +: 8];
  assign crc_next = crc_byte(crc_reg, cur_byte, crc_poly);

  // Single-cycle op results straight from the issue operands.
  always_comb begin
    single_res = '0;
    case (op)
      SP_BSWAP:  single_res = bswap_res;
      SP_POPCNT: single_res = {26'd0, sp_popcount(sp_inputs.rs1)};
      SP_CLZ:    single_res = {26'd0, sp_clz(sp_inputs.rs1)};
      default:   single_res = '0;
    endcase
  end

  // Result enqueue: issue-time ops, final CRC byte, or a held CRC result.
  always_comb begin
    push     = 1'b0;
    fifo_din = '{id: issue_id, rd: single_res};
    case (state_reg)
      IDLE: push = accept & (op != SP_CRC);
      CRC: begin
        fifo_din = '{id: id_reg, rd: crc_next};
        push     = (byte_idx_reg == 2'd3) & space;
      end
      HOLD: begin
        fifo_din = '{id: id_reg, rd: crc_reg};
        push     = space;
      end
      default: push = 1'b0;
    endcase
  end

  // Op FSM. HOLD covers a final CRC byte that finds the buffer full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      byte_idx_reg <= '0;
      crc_reg      <= '0;
      rs1_reg      <= '0;
      id_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept && op == SP_CRC) begin
            state_reg    <= CRC;
            byte_idx_reg <= '0;
            crc_reg      <= sp_inputs.rs2;
            rs1_reg      <= sp_inputs.rs1;
            id_reg       <= issue_id;
          end
        end
        CRC: begin
          crc_reg      <= crc_next;
          byte_idx_reg <= byte_idx_reg + 2'd1;
          if (byte_idx_reg == 2'd3) begin
            state_reg <= space ? IDLE : HOLD;
          end
        end
        HOLD: begin
          if (space) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  sp_unit_fifo #(
    .DATA_WIDTH($bits(sp_result_t)),
    .FIFO_DEPTH(RESULT_DEPTH)
  ) u_result_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (wb_ack),
    .data_in  (fifo_din),
    .data_out (fifo_dout),
    .valid    (fifo_valid),
    .full     (fifo_full)
  );

  assign wb_done = fifo_valid;
  assign wb_id   = fifo_dout.id;
  assign wb_rd   = fifo_dout.rd;

endmodule

// File: tb/tb_sp_unit.sv
// Directed plus randomized bench for sp_unit with an in-order scoreboard.
module tb_sp_unit;
  import sp_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_new_request = 1'b0;
  logic        wb_ack = 1'b0;
  logic        issue_ready, wb_done;
  id_t         issue_id, wb_id;
  sp_inputs_t  sp_inputs;
  logic [31:0] wb_rd;

  sp_unit #(.RESULT_DEPTH(2), .CRC_POLY(32'hEDB88320)) dut (
    .clk               (clk),
    .rst               (rst),
    .issue_new_request (issue_new_request),
    .issue_ready       (issue_ready),
    .issue_id          (issue_id),
    .sp_inputs         (sp_inputs),
    .wb_done           (wb_done),
    .wb_ack            (wb_ack),
    .wb_id             (wb_id),
    .wb_rd             (wb_rd)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_acc = 0;
  int         base;
  bit         acc_flag;
  sp_result_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Software CRC: reflected, no final inversion, low byte first.
  function automatic logic [31:0] crc_ref(input logic [31:0] init, input logic [31:0] data,
                                          input logic [31:0] poly);
    logic [31:0] c;
    c = init;
    for (int k = 0; k < 4; k++) begin
      c = c ^ ((data >> (8 * k)) & 32'hFF);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ poly) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] poly);
    int n;
    case (op)
      3'd0: return {a[7:0], a[15:8], a[23:16], a[31:24]};
      3'd1: return 32'($countones(a));
      3'd2: begin
        n = 0;
        while (n < 32 && a[31-n] == 1'b0) n++;
        return 32'(n);
      end
      3'd3: return crc_ref(b, a, poly);
      default: return 32'h0;
    endcase
  endfunction

  // One clock: retire/check at the falling edge, record acceptance, advance.
  task automatic cycle();
    logic [31:0] poly;
    sp_result_t  e;
    @(negedge clk);
    acc_flag = 1'b0;
    if (wb_done === 1'b1 && wb_ack === 1'b1) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_bad++;
        $error("FAIL wb_spurious observed id=%0d rd=%08h expected no result", wb_id, wb_rd);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wb_id", 32'(wb_id), 32'(e.id));
        chk("wb_rd", wb_rd, e.rd);
        $display("retire id=%0d rd=%08h", wb_id, wb_rd);
      end
    end
    if (issue_new_request === 1'b1 && issue_ready === 1'b1) begin
`ifdef SP_UNIT_CRC32C_EN
      poly = (sp_inputs.fn7 == 7'h01) ? 32'h82F63B78 : 32'hEDB88320;
`else
      poly = 32'hEDB88320;
`endif
      e.id = issue_id;
      e.rd = ref_result(sp_inputs.fn3[2:0], sp_inputs.rs1, sp_inputs.rs2, poly);
      exp_q.push_back(e);
      acc_flag = 1'b1;
      n_acc++;
      $display("issue id=%0d op=%0d rs1=%08h rs2=%08h fn7=%02h", issue_id,
               sp_inputs.fn3[2:0], sp_inputs.rs1, sp_inputs.rs2, sp_inputs.fn7);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input id_t id, input logic [6:0] fn7);
    issue_new_request = 1'b1;
    issue_id          = id;
    sp_inputs.fn3     = {4'($urandom), op};
    sp_inputs.fn7     = fn7;
    sp_inputs.rs1     = a;
    sp_inputs.rs2     = b;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input id_t id, input logic [6:0] fn7);
    set_req(op, a, b, id, fn7);
    acc_flag = 1'b0;
    for (int k = 0; k < 40 && !acc_flag; k++) cycle();
    chk("issue_accept", {31'd0, acc_flag}, 32'd1);
    issue_new_request = 1'b0;
  endtask

  task automatic drain();
    issue_new_request = 1'b0;
    wb_ack = 1'b1;
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) cycle();
    cycle();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_done_low", {31'd0, wb_done}, 32'd0);
  endtask

  function automatic logic [6:0] rand_fn7();
`ifdef SP_UNIT_CRC32C_EN
    return ($urandom_range(0, 1) != 0) ? 7'h01 : 7'($urandom);
`else
    return 7'($urandom);
`endif
  endfunction

  initial begin
    sp_inputs = '0;
    issue_id  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_issue_ready", {31'd0, issue_ready}, 32'd0);
    chk("rst_wb_done", {31'd0, wb_done}, 32'd0);
    chk("rst_wb_id", 32'(wb_id), 32'd0);
    chk("rst_wb_rd", wb_rd, 32'd0);
    rst = 1'b0;
    #1;
    chk("release_ready", {31'd0, issue_ready}, 32'd1);

    // BSWAP, result visible the cycle after acceptance
    wb_ack = 1'b1;
    set_req(3'd0, 32'h11223344, $urandom, 3'd5, 7'd0);
    cycle();
    issue_new_request = 1'b0;
    chk("bswap_accept", {31'd0, acc_flag}, 32'd1);
    chk("bswap_done_t1", {31'd0, wb_done}, 32'd1);
    chk("bswap_rd", wb_rd, 32'h44332211);
    chk("bswap_id", 32'(wb_id), 32'd5);
    cycle();

    // Back-to-back POPCNT / CLZ / CLZ(0), one result per cycle
    base = n_acc;
    set_req(3'd1, 32'hF0F00001, $urandom, 3'd1, 7'd0);
    cycle();
    set_req(3'd2, 32'h00008000, $urandom, 3'd2, 7'd0);
    chk("popcnt_rd", wb_rd, 32'd9);
    cycle();
    set_req(3'd2, 32'h00000000, $urandom, 3'd3, 7'd0);
    chk("clz_rd", wb_rd, 32'd16);
    cycle();
    issue_new_request = 1'b0;
    chk("clz_zero_rd", wb_rd, 32'd32);
    chk("b2b_accepts", 32'(n_acc - base), 32'd3);
    cycle();

    // CRC32 of "1234": busy four cycles, result at T+5
    set_req(3'd3, 32'h34333231, 32'hFFFFFFFF, 3'd6, 7'd0);
    cycle();
    issue_new_request = 1'b0;
    chk("crc_accept", {31'd0, acc_flag}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      chk("crc_busy_ready", {31'd0, issue_ready}, 32'd0);
      chk("crc_busy_done", {31'd0, wb_done}, 32'd0);
      cycle();
    end
    chk("crc_done_t5", {31'd0, wb_done}, 32'd1);
    chk("crc_value", wb_rd ^ 32'hFFFFFFFF, 32'h9BE3E0A3);
    chk("crc_id", 32'(wb_id), 32'd6);
    cycle();

    // Backpressure: full buffer blocks issue until wb_ack
    wb_ack = 1'b0;
    issue(3'd0, $urandom, $urandom, 3'd1, rand_fn7());
    issue(3'd0, $urandom, $urandom, 3'd2, rand_fn7());
    set_req(3'd0, $urandom, $urandom, 3'd3, rand_fn7());
    #1;
    chk("bp_ready_full", {31'd0, issue_ready}, 32'd0);
    base = n_acc;
    cycle();
    cycle();
    chk("bp_no_accept", 32'(n_acc - base), 32'd0);
    wb_ack = 1'b1;
    #1;
    chk("bp_ready_on_ack", {31'd0, issue_ready}, 32'd1);
    cycle();
    chk("bp_accept_on_ack", {31'd0, acc_flag}, 32'd1);
    wb_ack = 1'b0;
    issue_new_request = 1'b0;
    drain();

    // CRC issued against a full buffer
    wb_ack = 1'b0;
    issue(3'd0, $urandom, $urandom, 3'd4, rand_fn7());
    issue(3'd0, $urandom, $urandom, 3'd5, rand_fn7());
    set_req(3'd3, $urandom, $urandom, 3'd7, rand_fn7());
    base = n_acc;
    repeat (3) begin
      chk("full_crc_ready", {31'd0, issue_ready}, 32'd0);
      cycle();
    end
    chk("full_crc_wait", 32'(n_acc - base), 32'd0);
    wb_ack = 1'b1;
    cycle();
    wb_ack = 1'b0;
    issue_new_request = 1'b0;
    chk("full_crc_accept", {31'd0, acc_flag}, 32'd1);
    repeat (6) cycle();
    chk("full_crc_queued", {31'd0, wb_done}, 32'd1);
    chk("full_crc_ready_after", {31'd0, issue_ready}, 32'd0);
    drain();

    // Asynchronous reset in the byte_idx==2 cycle with one buffered result
    wb_ack = 1'b0;
    issue(3'd0, $urandom, $urandom, 3'd1, rand_fn7());
    issue(3'd3, $urandom, $urandom, 3'd2, rand_fn7());
    cycle();
    cycle();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_done", {31'd0, wb_done}, 32'd0);
    chk("rst_mid_ready", {31'd0, issue_ready}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, issue_ready}, 32'd1);
    chk("post_rst_done", {31'd0, wb_done}, 32'd0);
    chk("post_rst_rd", wb_rd, 32'd0);
    wb_ack = 1'b1;
    repeat (8) cycle();
    chk("post_rst_no_result", {31'd0, wb_done}, 32'd0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0)
        set_req(3'($urandom_range(0, 7)), $urandom, $urandom, 3'($urandom), rand_fn7());
      else
        issue_new_request = 1'b0;
      wb_ack = ($urandom_range(0, 2) != 0);
      cycle();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
